sub_bytes_sequencer: RTL and testbench
======================================

SUB_BYTES_SEQUENCER -- requirements
Module: SubBytesSequencer

Interface
REQ-001 SHALL have parameter LANES, default 4: S-box lanes per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port inverse  input  1  0 = SubBytes, 1 = inverse SubBytes; sampled at accept.
REQ-005 SHALL have port in_valid  input  1  in_state and inverse are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_state  input  128  state to substitute; byte 0 = bits [127:120].
REQ-008 SHALL have port out_valid  output  1  out_state holds a complete result.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port out_state  output  128  substituted state, same byte order.
REQ-011 SHALL have port busy  output  1  high in BUSY state.

Function
REQ-012 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready in IDLE, and in DONE only when out_ready is high; otherwise low.
REQ-014 SHALL accept on in_valid & in_ready: capture in_state into working register, latch inverse, clear beat counter, enter BUSY.
REQ-015 SHALL, per BUSY cycle, replace bytes [beat*LANES .. beat*LANES+LANES-1] with their forward or inverse S-box value and increment beat.
REQ-016 SHALL use beat counter width $clog2(16/LANES) (min 1 bit), wrapping to 0 after last beat.
REQ-017 SHALL leave the BUSY state for DONE on the cycle the last beat (16/LANES-1) is written; accept-to-out_valid latency = 16/LANES cycles (LANES=4: 4 cycles).
REQ-018 SHALL hold out_valid high and out_state stable in DONE until out_ready is high.
REQ-019 SHALL, in DONE with out_ready high: if in_valid high, accept the new input and enter BUSY (back-to-back); else enter IDLE.
REQ-020 SHALL ignore in_valid, in_state and inverse in BUSY, and ignore changes to inverse after accept.
REQ-021 SHALL drive out_state from the working register; its value outside DONE is don't-care for consumers but deterministic.
REQ-022 SHALL, for LANES=16, complete in one BUSY cycle.

Reset
REQ-023 SHALL, on reset_n low, asynchronously force state IDLE, beat 0, working register 0, latched inverse 0, in_ready 1, out_valid 0, busy 0, out_state 0.
REQ-024 SHALL abandon any in-flight or undelivered result on reset mid-operation; no out_valid after reset release until a new accept.
REQ-025 SHALL begin accepting on the first rising edge after reset_n deasserts.

Structure
REQ-026 SHALL take forward and inverse S-box tables and the 128-bit state typedef from the shared AESDefinitions package.
REQ-027 SHALL place the FSM state enum in AESDefinitions for reuse by other sequencers.
REQ-028 SHALL instantiate LANES copies of one combinational sub-module SBoxLane (8-bit in, inverse select, 8-bit out).
REQ-029 SHALL contain no combinational path from in_valid to out_valid.

Verification
REQ-030 SHALL cover: LANES=4, inverse=0, in_state 193de3bea0f4e22b9ac68d2ae9f84808 -> out_valid 4 cycles after accept, out_state d42711aee0bf98f1b8b45de51e415230.
REQ-031 SHALL cover: inverse=1, in_state d42711aee0bf98f1b8b45de51e415230 -> out_state 193de3bea0f4e22b9ac68d2ae9f84808.
REQ-032 SHALL cover: in_state all 00 forward -> all 63; all 53 forward -> all ED; all 63 inverse -> all 00.
REQ-033 SHALL cover: out_ready held low 10 cycles -> out_valid and out_state stable, in_ready 0; then out_ready=1 with in_valid=1 -> new accept same cycle, next result 4 cycles later.
REQ-034 SHALL cover: reset_n pulsed low during beat 2 -> outputs at reset values immediately, no out_valid until next accept.
REQ-035 SHALL cover: LANES=1 and LANES=16 builds with REQ-030 vector -> latencies 16 and 1 cycles, identical out_state.

Source files
------------

// File: rtl/sub_bytes_sequencer_pkg.sv
// Shared AES definitions: 128-bit state type, sequencer FSM states and the
// forward / inverse S-box tables used by every SubBytes datapath.
package sub_bytes_sequencer_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } seq_state_t;

  // Tables are written entry 0 first, so entry 0 sits in the top element;
  // look them up with the bitwise complement of the byte value.
  localparam logic [255:0][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/sub_bytes_sequencer_sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of one byte.
module sub_bytes_sequencer_sbox_lane
  import sub_bytes_sequencer_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inverse,
  output logic [7:0] byte_out
);

  logic [7:0] table_idx;

  assign table_idx = ~byte_in;
  assign byte_out  = inverse ? SBOX_INV[table_idx] : SBOX_FWD[table_idx];

endmodule

// File: rtl/sub_bytes_sequencer.sv
// Multi-cycle SubBytes sequencer: substitutes LANES bytes of the working state
// per cycle with a valid/ready handshake on both sides.
module sub_bytes_sequencer
  import sub_bytes_sequencer_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inverse,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned BEATS  = 16 / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  seq_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  aes_state_t        work_q, work_d;
  logic              inverse_q;
  logic              accept;
  logic [7:0]        lane_in  [LANES];
  logic [7:0]        lane_out [LANES];

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = work_q;

  // Lane g works on byte beat*LANES+g; byte 0 is the most significant byte.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_in[g] = work_q[8*(15 - (32'(beat_q)*LANES + g)) +: 8];

    sub_bytes_sequencer_sbox_lane u_lane (
      .byte_in  (lane_in[g]),
      .inverse  (inverse_q),
      .byte_out (lane_out[g])
    );
  end

  always_comb begin
    work_d = work_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      work_d[8*(15 - (32'(beat_q)*LANES + l)) +: 8] = lane_out[l];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (beat_q == LAST_BEAT) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_q    <= '0;
      work_q    <= '0;
      inverse_q <= 1'b0;
    end else if (accept) begin
      beat_q    <= '0;
      work_q    <= in_state;
      inverse_q <= inverse;
    end else if (state_q == BUSY) begin
      beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      work_q <= work_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// Self-checking bench for sub_bytes_sequencer at LANES = 4, 1 and 16 against
// an S-box model derived from GF(2^8) inversion and the AES affine map.
module tb_sub_bytes_sequencer;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic         inverse = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state  = '0;
  logic         iv [3] = '{1'b0, 1'b0, 1'b0};
  logic         ir [3];
  logic         ov [3];
  logic         bz [3];
  logic [127:0] os [3];

  int checks   = 0;
  int failures = 0;
  int lat [3]  = '{4, 16, 1};

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  localparam logic [127:0] VEC_PLAIN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] VEC_SUB   = 128'hd42711aee0bf98f1b8b45de51e415230;

  always #5 clock = ~clock;

  sub_bytes_sequencer #(.LANES(4)) dut_l4 (
    .clock(clock), .reset_n(reset_n), .inverse(inverse), .in_valid(iv[0]),
    .in_ready(ir[0]), .in_state(in_state), .out_valid(ov[0]),
    .out_ready(out_ready), .out_state(os[0]), .busy(bz[0])
  );

  sub_bytes_sequencer #(.LANES(1)) dut_l1 (
    .clock(clock), .reset_n(reset_n), .inverse(inverse), .in_valid(iv[1]),
    .in_ready(ir[1]), .in_state(in_state), .out_valid(ov[1]),
    .out_ready(out_ready), .out_state(os[1]), .busy(bz[1])
  );

  sub_bytes_sequencer #(.LANES(16)) dut_l16 (
    .clock(clock), .reset_n(reset_n), .inverse(inverse), .in_valid(iv[2]),
    .in_ready(ir[2]), .in_state(in_state), .out_valid(ov[2]),
    .out_ready(out_ready), .out_state(os[2]), .busy(bz[2])
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] b;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      b = '0;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
      end
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    logic [7:0]   x;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      x = st[127-8*b -: 8];
      r[127-8*b -: 8] = inv ? inv_tab[x] : fwd_tab[x];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts rising edges until out_valid is seen at the following falling edge.
  task automatic wait_done(input int sel, input bit scramble, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (scramble) begin
        iv[sel]  = 1'($urandom);
        in_state = {$urandom, $urandom, $urandom, $urandom};
        inverse  = 1'($urandom);
      end
      if (ov[sel]) break;
    end
    iv[sel] = 1'b0;
  endtask

  task automatic transact(input int sel, input logic [127:0] st, input logic inv,
                          input logic [127:0] exp, input int stall, input string tag);
    int n;
    iv[sel]   = 1'b1;
    in_state  = st;
    inverse   = inv;
    out_ready = 1'b0;
    check($sformatf("%s_in_ready", tag), 128'(ir[sel]), 128'(1));
    @(posedge clock);
    wait_done(sel, 1'b1, n);
    check($sformatf("%s_latency", tag), 128'(n), 128'(lat[sel]));
    check($sformatf("%s_state", tag), os[sel], exp);
    repeat (stall) @(negedge clock);
    check($sformatf("%s_hold_valid", tag), 128'(ov[sel]), 128'(1));
    check($sformatf("%s_hold_state", tag), os[sel], exp);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check($sformatf("%s_drained", tag), 128'(ov[sel]), 128'(0));
  endtask

  initial begin
    int n;
    int seen;
    logic [127:0] b_state;
    logic [127:0] st;
    logic         inv;
    int           sel;

    build_tables();

    #1 reset_n = 1'b0;
    #1;
    check("rst_in_ready",  128'(ir[0]), 128'(1));
    check("rst_out_valid", 128'(ov[0]), 128'(0));
    check("rst_busy",      128'(bz[0]), 128'(0));
    check("rst_out_state", os[0], '0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    transact(0, VEC_PLAIN, 1'b0, VEC_SUB, 3, "fwd_vec");
    transact(0, VEC_SUB, 1'b1, VEC_PLAIN, 0, "inv_vec");
    transact(0, '0, 1'b0, {16{8'h63}}, 1, "zero_fwd");
    transact(0, {16{8'h53}}, 1'b0, {16{8'hed}}, 0, "x53_fwd");
    transact(0, {16{8'h63}}, 1'b1, '0, 2, "x63_inv");

    // Stall the consumer, then back-to-back accept while draining.
    iv[0] = 1'b1; in_state = VEC_PLAIN; inverse = 1'b0; out_ready = 1'b0;
    @(posedge clock);
    wait_done(0, 1'b0, n);
    check("b2b_first_latency", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clock);
      check("stall_valid", 128'(ov[0]), 128'(1));
      check("stall_state", os[0], VEC_SUB);
      check("stall_in_ready", 128'(ir[0]), 128'(0));
    end
    b_state  = {$urandom, $urandom, $urandom, $urandom};
    in_state = b_state; inverse = 1'b1; iv[0] = 1'b1; out_ready = 1'b1;
    #1 check("b2b_in_ready", 128'(ir[0]), 128'(1));
    @(posedge clock);
    @(negedge clock);
    iv[0] = 1'b0; out_ready = 1'b0;
    check("b2b_valid_drop", 128'(ov[0]), 128'(0));
    check("b2b_busy", 128'(bz[0]), 128'(1));
    wait_done(0, 1'b0, n);
    check("b2b_second_latency", 128'(n), 128'(4));
    check("b2b_second_state", os[0], model_sub(b_state, 1'b1));
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;

    // Reset while beat 2 is pending.
    iv[0] = 1'b1; in_state = VEC_PLAIN; inverse = 1'b0;
    @(posedge clock);
    @(negedge clock);
    iv[0] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("mid_busy_before_rst", 128'(bz[0]), 128'(1));
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  128'(ir[0]), 128'(1));
    check("mid_rst_out_valid", 128'(ov[0]), 128'(0));
    check("mid_rst_busy",      128'(bz[0]), 128'(0));
    check("mid_rst_out_state", os[0], '0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (ov[0]) seen++;
    end
    check("post_rst_no_valid", 128'(seen), 128'(0));

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 2));
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom);
      transact(sel, st, inv, model_sub(st, inv), int'($urandom_range(0, 3)),
               $sformatf("rand%0d_l%0d", t, sel));
    end

    transact(1, VEC_PLAIN, 1'b0, VEC_SUB, 0, "lanes1_vec");
    transact(2, VEC_PLAIN, 1'b0, VEC_SUB, 0, "lanes16_vec");
    transact(2, VEC_SUB, 1'b1, VEC_PLAIN, 1, "lanes16_inv");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
